// File: rtl/writeback_arbiter_pkg.sv
// Shared constants and requester encoding for the register-file writeback arbiter.
// The round-robin pointer and grant selection both use req_e.
package writeback_arbiter_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ID_WIDTH   = 4;
    localparam int NUM_REGS   = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    function automatic req_e other_side(input req_e side);
        return (side == REQ_ALU) ? REQ_MEM : REQ_ALU;
    endfunction

endpackage

// File: rtl/wb_skid_entry.sv
// One-entry request buffer for a single writeback producer.
// Also exports the one-hot pending mask for its buffered destination register.
module wb_skid_entry
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = writeback_arbiter_pkg::DATA_WIDTH,
    parameter int ID_WIDTH   = writeback_arbiter_pkg::ID_WIDTH,
    parameter int NUM_REGS   = writeback_arbiter_pkg::NUM_REGS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  accept,
    input  logic                  drain,
    input  logic [ID_WIDTH-1:0]   id_in,
    input  logic [DATA_WIDTH-1:0] value_in,
    output logic                  ready,
    output logic                  full,
    output logic [ID_WIDTH-1:0]   id,
    output logic [DATA_WIDTH-1:0] value,
    output logic [NUM_REGS-1:0]   pending_mask
);

    // Handshake: ready = ~full & ~reset; a transfer happens at a rising edge
    // where valid & ready. A full entry refuses everything until it drains,
    // so accept and drain can never coincide.
    assign ready = ~full & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            full  <= 1'b0;
            id    <= '0;
            value <= '0;
        end else if (accept) begin
            full  <= 1'b1;
            id    <= id_in;
            value <= value_in;
        end else if (drain) begin
            full  <= 1'b0;
        end
    end

    // Register 0 is never a real destination, so it never marks a hazard.
    always_comb begin
        pending_mask = '0;
        if (full && (id != '0)) begin
            pending_mask[id] = 1'b1;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register_block write port between the ALU and memory-load paths.
// Buffered requests are granted round-robin and presented for exactly one cycle.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = writeback_arbiter_pkg::DATA_WIDTH,
    parameter int ID_WIDTH   = writeback_arbiter_pkg::ID_WIDTH,
    parameter int NUM_REGS   = writeback_arbiter_pkg::NUM_REGS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ID_WIDTH-1:0]   alu_id,
    input  logic [DATA_WIDTH-1:0] alu_value,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ID_WIDTH-1:0]   mem_id,
    input  logic [DATA_WIDTH-1:0] mem_value,
    output logic [ID_WIDTH-1:0]   write_id,
    output logic [DATA_WIDTH-1:0] write_value,
    output logic [NUM_REGS-1:0]   pending
);

    logic                  alu_full;
    logic                  mem_full;
    logic                  alu_accept;
    logic                  mem_accept;
    logic                  alu_drain;
    logic                  mem_drain;
    logic [ID_WIDTH-1:0]   alu_buf_id;
    logic [ID_WIDTH-1:0]   mem_buf_id;
    logic [DATA_WIDTH-1:0] alu_buf_value;
    logic [DATA_WIDTH-1:0] mem_buf_value;
    logic [NUM_REGS-1:0]   alu_mask;
    logic [NUM_REGS-1:0]   mem_mask;

    req_e rr;
    req_e grant_side;
    logic grant_valid;

    assign alu_accept = alu_valid & alu_ready;
    assign mem_accept = mem_valid & mem_ready;

    wb_skid_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_alu_entry (
        .clock        (clock),
        .reset        (reset),
        .accept       (alu_accept),
        .drain        (alu_drain),
        .id_in        (alu_id),
        .value_in     (alu_value),
        .ready        (alu_ready),
        .full         (alu_full),
        .id           (alu_buf_id),
        .value        (alu_buf_value),
        .pending_mask (alu_mask)
    );

    wb_skid_entry #(
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_mem_entry (
        .clock        (clock),
        .reset        (reset),
        .accept       (mem_accept),
        .drain        (mem_drain),
        .id_in        (mem_id),
        .value_in     (mem_value),
        .ready        (mem_ready),
        .full         (mem_full),
        .id           (mem_buf_id),
        .value        (mem_buf_value),
        .pending_mask (mem_mask)
    );

    // rr only matters on a tie; single-buffer grants still rotate it.
    always_comb begin
        grant_valid = 1'b0;
        grant_side  = rr;
        if (!hold) begin
            if (alu_full && mem_full) begin
                grant_valid = 1'b1;
                grant_side  = rr;
            end else if (alu_full) begin
                grant_valid = 1'b1;
                grant_side  = REQ_ALU;
            end else if (mem_full) begin
                grant_valid = 1'b1;
                grant_side  = REQ_MEM;
            end
        end
    end

    assign alu_drain = grant_valid && (grant_side == REQ_ALU);
    assign mem_drain = grant_valid && (grant_side == REQ_MEM);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr          <= REQ_ALU;
            write_id    <= '0;
            write_value <= '0;
        end else if (grant_valid) begin
            rr <= other_side(grant_side);
            if (grant_side == REQ_ALU) begin
                write_id    <= alu_buf_id;
                write_value <= alu_buf_value;
            end else begin
                write_id    <= mem_buf_id;
                write_value <= mem_buf_value;
            end
        end else begin
            write_id    <= '0;
            write_value <= '0;
        end
    end

    // A drained entry drops its bit at the same edge its write reaches write_id.
    assign pending = alu_mask | mem_mask;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_writeback_arbiter;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int NR = 16;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] value;
    } entry_t;

    logic          clock;
    logic          reset;
    logic          hold;
    logic          alu_valid;
    logic          alu_ready;
    logic [IW-1:0] alu_id;
    logic [DW-1:0] alu_value;
    logic          mem_valid;
    logic          mem_ready;
    logic [IW-1:0] mem_id;
    logic [DW-1:0] mem_value;
    logic [IW-1:0] write_id;
    logic [DW-1:0] write_value;
    logic [NR-1:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_arbiter #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .NUM_REGS   (NR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hold        (hold),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_id      (alu_id),
        .alu_value   (alu_value),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_id      (mem_id),
        .mem_value   (mem_value),
        .write_id    (write_id),
        .write_value (write_value),
        .pending     (pending)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: each requester holds at most one entry in a queue
    entry_t q_alu[$];
    entry_t q_mem[$];
    entry_t exp_q[$];
    bit     m_rr_mem = 1'b0;
    bit     model_live = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            q_alu.delete();
            q_mem.delete();
            exp_q.delete();
            m_rr_mem   = 1'b0;
            model_live = 1'b1;
        end else begin
            bit acc_a;
            bit acc_m;
            int pick;
            acc_a = alu_valid && (q_alu.size() == 0);
            acc_m = mem_valid && (q_mem.size() == 0);
            pick  = -1;
            if (!hold) begin
                if (q_alu.size() != 0 && q_mem.size() != 0) pick = m_rr_mem ? 1 : 0;
                else if (q_alu.size() != 0) pick = 0;
                else if (q_mem.size() != 0) pick = 1;
            end
            exp_q.delete();
            if (pick == 0) begin
                exp_q.push_back(q_alu.pop_front());
                m_rr_mem = 1'b1;
            end else if (pick == 1) begin
                exp_q.push_back(q_mem.pop_front());
                m_rr_mem = 1'b0;
            end
            if (acc_a) q_alu.push_back({alu_id, alu_value});
            if (acc_m) q_mem.push_back({mem_id, mem_value});
        end
    end

    // scoreboard: every cycle after the first reset edge
    always @(negedge clock) begin
        if (model_live) begin
            entry_t        e;
            logic [NR-1:0] pm;
            e  = (exp_q.size() != 0) ? exp_q[0] : '0;
            pm = '0;
            if (q_alu.size() != 0 && q_alu[0].id != 0) pm[q_alu[0].id] = 1'b1;
            if (q_mem.size() != 0 && q_mem[0].id != 0) pm[q_mem[0].id] = 1'b1;
            check("model_write_id", write_id, e.id);
            check("model_write_value", write_value, e.value);
            check("model_pending", pending, pm);
            check("model_alu_ready", alu_ready, !reset && q_alu.size() == 0);
            check("model_mem_ready", mem_ready, !reset && q_mem.size() == 0);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic send_alu(input logic [IW-1:0] id, input logic [DW-1:0] value);
        alu_valid = 1'b1;
        alu_id    = id;
        alu_value = value;
    endtask

    task automatic send_mem(input logic [IW-1:0] id, input logic [DW-1:0] value);
        mem_valid = 1'b1;
        mem_id    = id;
        mem_value = value;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] a_id;
        logic [IW-1:0] m_id;
        bit a_acc;
        bit m_acc;

        reset = 1'b1;
        hold  = 1'b0;
        alu_valid = 1'b0; alu_id = '0; alu_value = '0;
        mem_valid = 1'b0; mem_id = '0; mem_value = '0;
        step();
        step();
        at_neg();
        check("rst_write_id", write_id, 0);
        check("rst_write_value", write_value, 0);
        check("rst_pending", pending, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);

        // single ALU write
        step();
        reset = 1'b0;
        send_alu(4'd2, 8'h55);
        step();
        idle();
        at_neg();
        check("single_alu_ready", alu_ready, 0);
        check("single_pending", pending, 16'h0004);
        check("single_write_id_early", write_id, 0);
        step();
        at_neg();
        check("single_write_id", write_id, 2);
        check("single_write_value", write_value, 8'h55);
        check("single_pending_clear", pending, 0);
        step();
        at_neg();
        check("single_write_id_after", write_id, 0);

        // simultaneous requests, rr = ALU
        pulse_reset();
        send_alu(4'd3, 8'h11);
        send_mem(4'd5, 8'h22);
        step();
        idle();
        at_neg();
        check("both_pending0", pending, 16'h0028);
        step();
        at_neg();
        check("both_first_id", write_id, 3);
        check("both_first_value", write_value, 8'h11);
        check("both_pending1", pending, 16'h0020);
        step();
        at_neg();
        check("both_second_id", write_id, 5);
        check("both_second_value", write_value, 8'h22);
        check("both_pending2", pending, 0);
        step();

        // continuous streaming: ALU ids 1..7, MEM ids 9..15
        a_id = 4'd1;
        m_id = 4'd9;
        send_alu(a_id, 8'h10);
        send_mem(m_id, 8'h90);
        for (int k = 0; k < 14; k++) begin
            a_acc = alu_ready;
            m_acc = mem_ready;
            step();
            if (a_acc) begin
                a_id = (a_id == 4'd7) ? 4'd1 : a_id + 4'd1;
                send_alu(a_id, 8'h10 + 8'(k));
            end
            if (m_acc) begin
                m_id = (m_id == 4'd15) ? 4'd9 : m_id + 4'd1;
                send_mem(m_id, 8'h90 + 8'(k));
            end
            at_neg();
            if (k >= 1) begin
                check("stream_nonzero", write_id != 0, 1);
                check("stream_side_is_mem", write_id >= 8, (k % 2) == 0);
            end
        end
        idle();
        step(); step(); step();

        // hold with both buffers full
        pulse_reset();
        hold = 1'b1;
        send_alu(4'd6, 8'h66);
        send_mem(4'd7, 8'h77);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("hold_write_id", write_id, 0);
            check("hold_alu_ready", alu_ready, 0);
            check("hold_mem_ready", mem_ready, 0);
            check("hold_pending", pending, 16'h00C0);
            step();
        end
        hold = 1'b0;
        step();
        at_neg();
        check("release_first_id", write_id, 6);
        check("release_first_value", write_value, 8'h66);
        step();
        at_neg();
        check("release_second_id", write_id, 7);
        check("release_second_value", write_value, 8'h77);
        step();

        // id 0 consumes an arbitration slot
        pulse_reset();
        send_alu(4'd0, 8'hFF);
        send_mem(4'd9, 8'h3C);
        step();
        idle();
        at_neg();
        check("id0_pending", pending, 16'h0200);
        check("id0_alu_ready", alu_ready, 0);
        step();
        at_neg();
        check("id0_write_id", write_id, 0);
        check("id0_write_value", write_value, 8'hFF);
        check("id0_pending_after", pending, 16'h0200);
        step();
        at_neg();
        check("id0_next_id", write_id, 9);
        check("id0_next_value", write_value, 8'h3C);
        check("id0_pending_clear", pending, 0);
        step();

        // reset while both buffers are full
        hold = 1'b1;
        send_alu(4'd4, 8'h44);
        send_mem(4'd8, 8'h88);
        step();
        idle();
        at_neg();
        check("mid_pending_before", pending, 16'h0110);
        step();
        reset = 1'b1;
        hold  = 1'b0;
        step();
        at_neg();
        check("mid_write_id", write_id, 0);
        check("mid_pending", pending, 0);
        check("mid_alu_ready", alu_ready, 0);
        check("mid_mem_ready", mem_ready, 0);
        reset = 1'b0;
        step();
        at_neg();
        check("mid_alu_ready_after", alu_ready, 1);
        check("mid_mem_ready_after", mem_ready, 1);
        check("mid_write_id_after", write_id, 0);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Shares the single write port of register_block between two producers: the ALU result path and the memory-load path.
- Each requester gets a one-entry skid buffer with a registered-style valid/ready handshake. Buffered writes are granted round-robin and presented on write_id/write_value for exactly one cycle.
- Exports a pending-write mask so the instruction sequencer can stall on read-after-write hazards.

Parameters:
- DATA_WIDTH, 8, width of register values.
- ID_WIDTH, 4, width of register ids.
- NUM_REGS, 16, number of register ids tracked in pending; must equal 2**ID_WIDTH.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  sequencer stall; while 1, no grants are issued.
- alu_valid  in  1  ALU write request valid.
- alu_ready  out  1  ALU buffer can accept.
- alu_id  in  ID_WIDTH  ALU destination register.
- alu_value  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  memory-load write request valid.
- mem_ready  out  1  memory buffer can accept.
- mem_id  in  ID_WIDTH  load destination register.
- mem_value  in  DATA_WIDTH  loaded data.
- write_id  out  ID_WIDTH  to register_block write_id; 0 = no write.
- write_value  out  DATA_WIDTH  to register_block write_value.
- pending  out  NUM_REGS  bit i = a buffered write to register i is outstanding.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - both buffers empty
  - write_id = 0, write_value = 0
  - round-robin pointer rr = ALU
  - pending = 0
  - alu_ready = mem_ready = 0 while reset is high
- Handshake:
  - x_ready = ~x_full & ~reset.
  - A transfer occurs at a rising edge where x_valid & x_ready; the buffer captures id/value and sets full.
  - A full buffer accepts nothing until it drains.
  - Per-requester throughput is therefore at most 1 write per 2 cycles; aggregate throughput is 1 per cycle.
- Grant, evaluated each cycle when hold = 0:
  - Only one full buffer: grant it.
  - Both full: grant the side rr points to, then set rr to the other side.
  - Single-buffer grants also set rr to the other side.
  - Neither full: no grant.
- Output stage, registered at the same edge that clears the granted buffer:
  - Grant: write_id/write_value <= the granted entry.
  - No grant: write_id <= 0, write_value <= 0.
  - Each write is presented for exactly one cycle.
  - Latency: a request accepted at edge N appears on write_id after edge N+1 if uncontended; after edge N+2 if it loses arbitration.
- hold = 1:
  - Buffers retain their contents; rr is unchanged.
  - write_id/write_value go to 0 at the next edge.
  - Ready still reflects buffer empty, so empty buffers keep accepting.
- id 0: accepted and granted normally; presented as write_id = 0, which register_block ignores. Consumes an arbitration slot. Never sets pending.
- Same id in both buffers: granted in rr order, and the later grant wins in the register file. Preventing this ordering hazard is the sequencer's job, using pending.
- pending: combinational OR over full buffers of decode(id). Bit 0 is forced to 0. A bit clears in the same cycle the granted write appears on write_id.
- Reset mid-operation: buffered writes are discarded; the output drops to 0 at that edge.

Decomposition:
- Shared package holds DATA_WIDTH, ID_WIDTH, NUM_REGS and the requester encoding REQ_ALU = 0, REQ_MEM = 1 (used for rr).
- Natural sub-module: wb_skid_entry, one instance per requester. It contains the full flag, id/value registers, ready, an accept input, a drain input and the id decode feeding pending.

Test Plan:
- After reset, ALU sends id 2 / 0x55 alone:
  - accepted at edge N, alu_ready = 0 in the following cycle
  - pending = 0x0004 during cycle N+1
  - write_id = 2 / write_value = 0x55 for one cycle after edge N+1, then write_id = 0
- ALU (id 3 / 0x11) and MEM (id 5 / 0x22) transfer at the same edge, rr = ALU:
  - id 3 is written in the first cycle, id 5 in the next
  - pending goes 0x0028 -> 0x0020 -> 0x0000
- Both requesters stream continuously with distinct ids: grants alternate ALU, MEM, ALU, MEM; no cycle with write_id = 0 after the pipeline fills.
- hold = 1 with both buffers full for 3 cycles:
  - write_id = 0 throughout; both readys 0; pending is held
  - on release, grants resume starting with the rr side
- Request with id 0 / 0xFF: accepted and consumes a slot; write_id = 0; pending stays 0.
- Reset asserted while both buffers are full: next cycle write_id = 0, pending = 0, readys = 0; after deassert both readys = 1.
